// File: rtl/conv_dot_acc.sv
// Multi-lane dot-product engine with a registered adder tree and a windowed saturating accumulator.
// Optional build macro CONV_DOT_ACC_RELU_EN clamps negative results to zero (SIGNED=1 only).
module conv_dot_acc #(
    parameter int unsigned LANES  = 32,
    parameter int unsigned DW     = 4,
    parameter int unsigned SIGNED = 0,
    parameter int unsigned ACC_W  = 20,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [LANES*DW-1:0]   in_ifm,
    input  logic [LANES*DW-1:0]   in_weight,
    output logic                  out_valid,
    output logic [ACC_W-1:0]      out_ofm,
    output logic                  out_ovf,
    output logic [CNT_W-1:0]      out_count
);

    localparam int unsigned LOG2L = $clog2(LANES);
    localparam int unsigned PRW   = 2 * DW;
    localparam int unsigned PW    = PRW + 1;
    localparam int unsigned NP    = LANES / 2;
    localparam int unsigned TW    = PRW + LOG2L;
    localparam int unsigned EW    = ACC_W + 1;

    localparam logic [ACC_W-1:0] UMAX = '1;
    localparam logic [ACC_W-1:0] SMAX = UMAX >> 1;
    localparam logic [ACC_W-1:0] SMIN = ~SMAX;
    localparam logic [CNT_W-1:0] CMAX = '1;

    // Elaboration-time parameter sanity
    if (LANES < 2 || LANES > 64 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
        $error("conv_dot_acc: LANES must be a power of two in 2..64");
    end
    if (ACC_W < TW) begin : g_bad_accw
        $error("conv_dot_acc: ACC_W too narrow for the tile sum");
    end

    // Width extension helpers: sign-extend when SIGNED, zero-extend otherwise
    function automatic logic [PRW-1:0] ext_elem(input logic [DW-1:0] x);
        logic signed [DW-1:0] xs;
        xs = $signed(x);
        if (SIGNED != 0) return PRW'(xs);
        else             return PRW'(x);
    endfunction

    function automatic logic [PW-1:0] ext_prod(input logic [PRW-1:0] x);
        logic signed [PRW-1:0] xs;
        xs = $signed(x);
        if (SIGNED != 0) return PW'(xs);
        else             return PW'(x);
    endfunction

    function automatic logic [TW-1:0] ext_pair(input logic [PW-1:0] x);
        logic signed [PW-1:0] xs;
        xs = $signed(x);
        if (SIGNED != 0) return TW'(xs);
        else             return TW'(x);
    endfunction

    function automatic logic [EW-1:0] ext_tile(input logic [TW-1:0] x);
        logic signed [TW-1:0] xs;
        xs = $signed(x);
        if (SIGNED != 0) return EW'(xs);
        else             return EW'(x);
    endfunction

    function automatic logic [EW-1:0] ext_acc(input logic [ACC_W-1:0] x);
        logic signed [ACC_W-1:0] xs;
        xs = $signed(x);
        if (SIGNED != 0) return EW'(xs);
        else             return EW'(x);
    endfunction

    // Stage 1 registers: adjacent lane-pair sums
    logic [PW-1:0]    r_pair [NP];
    logic             r_v1;
    logic             r_l1;
    // Stage 2 registers: tile sum
    logic [TW-1:0]    r_tile;
    logic             r_v2;
    logic             r_l2;
    // Accumulate stage state
    logic             r_busy;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic [PW-1:0]    w_pair [NP];
    logic [TW-1:0]    w_tile;
    logic [EW-1:0]    w_sum;
    logic             w_sat_hit;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_ovf_nxt;
    logic [ACC_W-1:0] w_res;

    // Lane products and pair sums for the incoming beat
    always_comb begin
        for (int p = 0; p < int'(NP); p++) begin
            logic [PRW-1:0] a0, b0, a1, b1, m0, m1;
            a0 = ext_elem(in_ifm   [(2*p)*DW   +: DW]);
            b0 = ext_elem(in_weight[(2*p)*DW   +: DW]);
            a1 = ext_elem(in_ifm   [(2*p+1)*DW +: DW]);
            b1 = ext_elem(in_weight[(2*p+1)*DW +: DW]);
            m0 = PRW'(a0 * b0);
            m1 = PRW'(a1 * b1);
            w_pair[p] = ext_prod(m0) + ext_prod(m1);
        end
    end

    // Remaining adder tree over the registered pair sums
    always_comb begin
        w_tile = '0;
        for (int p = 0; p < int'(NP); p++) begin
            w_tile = w_tile + ext_pair(r_pair[p]);
        end
    end

    // Saturating accumulate, beat counter and sticky overflow
    always_comb begin
        w_sum     = (r_busy ? ext_acc(r_acc) : '0) + ext_tile(r_tile);
        w_sat_hit = 1'b0;
        w_acc_nxt = w_sum[ACC_W-1:0];
        if (SIGNED != 0) begin
            if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
                w_sat_hit = 1'b1;
                w_acc_nxt = w_sum[ACC_W] ? SMIN : SMAX;
            end
        end else if (w_sum[ACC_W]) begin
            w_sat_hit = 1'b1;
            w_acc_nxt = UMAX;
        end

        if (!r_busy)          w_cnt_nxt = CNT_W'(1);
        else if (r_cnt == CMAX) w_cnt_nxt = r_cnt;
        else                  w_cnt_nxt = CNT_W'(r_cnt + 1'b1);

        w_ovf_nxt = (r_busy & r_ovf) | w_sat_hit;

        w_res = w_acc_nxt;
`ifdef CONV_DOT_ACC_RELU_EN
        if (SIGNED != 0 && w_acc_nxt[ACC_W-1]) begin
            w_res = '0;
        end
`endif
    end

    // Pipeline stages 1 and 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < int'(NP); p++) begin
                r_pair[p] <= '0;
            end
            r_v1   <= 1'b0;
            r_l1   <= 1'b0;
            r_tile <= '0;
            r_v2   <= 1'b0;
            r_l2   <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            r_l1 <= in_valid & in_last;
            if (in_valid) begin
                for (int p = 0; p < int'(NP); p++) begin
                    r_pair[p] <= w_pair[p];
                end
            end
            r_v2 <= r_v1;
            r_l2 <= r_l1;
            if (r_v1) begin
                r_tile <= w_tile;
            end
        end
    end

    // Accumulator and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            out_valid <= 1'b0;
            out_ofm   <= '0;
            out_ovf   <= 1'b0;
            out_count <= '0;
        end else begin
            out_valid <= r_v2 & r_l2;
            if (r_v2) begin
                if (r_l2) begin
                    r_busy    <= 1'b0;
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    r_ovf     <= 1'b0;
                    out_ofm   <= w_res;
                    out_ovf   <= w_ovf_nxt;
                    out_count <= w_cnt_nxt;
                end else begin
                    r_busy <= 1'b1;
                    r_acc  <= w_acc_nxt;
                    r_cnt  <= w_cnt_nxt;
                    r_ovf  <= w_ovf_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_dot_acc.sv
// Scoreboard bench for conv_dot_acc: unsigned default instance plus a SIGNED=1 instance.
`timescale 1ns/1ps
module tb_conv_dot_acc;

    logic         clk;
    logic         rst_n;
    logic         in_valid, in_last;
    logic [127:0] in_ifm, in_weight;
    logic         u_valid, u_ovf;
    logic [19:0]  u_ofm;
    logic [7:0]   u_count;

    logic         s_in_valid, s_in_last;
    logic [127:0] s_in_ifm, s_in_weight;
    logic         s_valid, s_ovf;
    logic [19:0]  s_ofm;
    logic [7:0]   s_count;

    typedef struct {
        logic [19:0] ofm;
        logic        ovf;
        logic [7:0]  cnt;
        int          cyc;
    } exp_t;

    exp_t q_u[$];
    exp_t q_s[$];
    exp_t e_u, e_s;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    conv_dot_acc dut_u (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_last(in_last),
        .in_ifm(in_ifm), .in_weight(in_weight),
        .out_valid(u_valid), .out_ofm(u_ofm), .out_ovf(u_ovf), .out_count(u_count)
    );

    conv_dot_acc #(.SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_last(s_in_last),
        .in_ifm(s_in_ifm), .in_weight(s_in_weight),
        .out_valid(s_valid), .out_ofm(s_ofm), .out_ovf(s_ovf), .out_count(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitors: pop and compare whenever a result strobe is presented
    always @(negedge clk) begin
        if (rst_n && u_valid) begin
            if (q_u.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL u_unexpected_result: got ofm=%0d cnt=%0d expected no result", u_ofm, u_count);
            end else begin
                e_u = q_u.pop_front();
                chk("u_ofm",     64'(u_ofm),   64'(e_u.ofm));
                chk("u_ovf",     64'(u_ovf),   64'(e_u.ovf));
                chk("u_count",   64'(u_count), 64'(e_u.cnt));
                chk("u_latency", 64'(cyc),     64'(e_u.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && s_valid) begin
            if (q_s.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL s_unexpected_result: got ofm=%0h cnt=%0d expected no result", s_ofm, s_count);
            end else begin
                e_s = q_s.pop_front();
                chk("s_ofm",     64'(s_ofm),   64'(e_s.ofm));
                chk("s_ovf",     64'(s_ovf),   64'(e_s.ovf));
                chk("s_count",   64'(s_count), 64'(e_s.cnt));
                chk("s_latency", 64'(cyc),     64'(e_s.cyc));
            end
        end
    end

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic last);
        @(negedge clk);
        in_valid  = 1'b1;
        in_last   = last;
        in_ifm    = {32{a}};
        in_weight = {32{b}};
    endtask

    task automatic idle(input logic last);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = last;
    endtask

    task automatic push_u(input logic [19:0] ofm, input logic ovf, input logic [7:0] cnt);
        exp_t e;
        e.ofm = ofm; e.ovf = ovf; e.cnt = cnt; e.cyc = cyc + 3;
        q_u.push_back(e);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 20 && (q_u.size() != 0 || q_s.size() != 0); k++) begin
            idle(1'b0);
        end
        chk("drain_pending", 64'(q_u.size() + q_s.size()), 64'd0);
    endtask

    initial begin
        exp_t es;
        logic [19:0] s_exp;
        rst_n = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_ifm = '0; in_weight = '0;
        s_in_valid = 1'b0; s_in_last = 1'b0; s_in_ifm = '0; s_in_weight = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(u_valid), 64'd0);
        chk("rst_ofm",   64'(u_ofm),   64'd0);
        chk("rst_ovf",   64'(u_ovf),   64'd0);
        chk("rst_count", 64'(u_count), 64'd0);
        rst_n = 1'b1;

        // Single beat, max unsigned elements
        drive(4'hF, 4'hF, 1'b1); push_u(20'd7200, 1'b0, 8'd1);
        idle(1'b0);

        // Three all-ones beats with a gap carrying a stray last
        drive(4'h1, 4'h1, 1'b0);
        idle(1'b1);
        drive(4'h1, 4'h1, 1'b0);
        drive(4'h1, 4'h1, 1'b1); push_u(20'd96, 1'b0, 8'd3);
        idle(1'b0);

        // Back-to-back single-beat windows
        drive(4'hF, 4'hF, 1'b1); push_u(20'd7200, 1'b0, 8'd1);
        drive(4'h1, 4'h2, 1'b1); push_u(20'd64,   1'b0, 8'd1);
        idle(1'b0);

        // Signed instance: -8 * 7 over 32 lanes
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        s_in_valid = 1'b1; s_in_last = 1'b1;
        s_in_ifm = {32{4'h8}}; s_in_weight = {32{4'h7}};
`ifdef CONV_DOT_ACC_RELU_EN
        s_exp = 20'd0;
`else
        s_exp = 20'hFF900;
`endif
        es.ofm = s_exp; es.ovf = 1'b0; es.cnt = 8'd1; es.cyc = cyc + 3;
        q_s.push_back(es);
        @(negedge clk);
        s_in_valid = 1'b0; s_in_last = 1'b0;

        // Saturation over 146 beats, then a clean window
        for (int i = 1; i <= 146; i++) drive(4'hF, 4'hF, logic'(i == 146));
        push_u(20'hFFFFF, 1'b1, 8'd146);
        drive(4'hF, 4'hF, 1'b1); push_u(20'd7200, 1'b0, 8'd1);

        // Beat counter saturation without overflow
        for (int i = 1; i <= 300; i++) drive(4'h1, 4'h1, logic'(i == 300));
        push_u(20'd9600, 1'b0, 8'd255);
        wait_drain();

        // Asynchronous reset mid-window
        drive(4'h1, 4'h1, 1'b0);
        drive(4'h1, 4'h1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ofm",   64'(u_ofm),   64'd0);
        chk("mid_rst_count", 64'(u_count), 64'd0);
        chk("mid_rst_valid", 64'(u_valid), 64'd0);
        chk("mid_rst_s_ofm", 64'(s_ofm),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'h1, 4'h1, 1'b1); push_u(20'd32, 1'b0, 8'd1);
        idle(1'b0);
        wait_drain();

        // Result holds while idle
        repeat (3) idle(1'b0);
        chk("hold_ofm",   64'(u_ofm),   64'd32);
        chk("hold_count", 64'(u_count), 64'd1);
        chk("hold_valid", 64'(u_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_dot_acc.md
Name: conv_dot_acc

Overview:
- Parametrised multi-lane dot-product engine with window accumulation.
- Each beat multiplies LANES pairs of DW-bit IFM/weight elements and reduces them through a registered adder tree.
- Tile sums are accumulated across a variable-length window delimited by in_last; the block emits one saturated result per window.
- Sits between the IFM/weight fetch stage and the output feature-map writer in the convolution datapath.

Parameters:
- LANES, 32, element pairs per beat; power of two, 2..64.
- DW, 4, bits per IFM and weight element.
- SIGNED, 0, 0 = unsigned elements; 1 = two's-complement elements and signed accumulation.
- ACC_W, 20, accumulator/output width; must be >= 2*DW+log2(LANES).
- CNT_W, 8, width of beat counter reported with each result.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  beat valid
- in_last  in  1  final beat of window; qualified by in_valid
- in_ifm  in  LANES*DW  lane i at bits [i*DW +: DW]
- in_weight  in  LANES*DW  lane i at bits [i*DW +: DW]
- out_valid  out  1  single-cycle result strobe
- out_ofm  out  ACC_W  window result; holds until next result
- out_ovf  out  1  window saturated; valid with out_valid, held with out_ofm
- out_count  out  CNT_W  beats in window; saturates at 2^CNT_W-1

Behaviour:
- Reset:
  - Clock: clk. Reset: rst_n, asynchronous, active-low.
  - Asserting reset clears every register: out_valid=0, out_ofm=0, out_ovf=0, out_count=0, accumulator empty, pipeline valids 0.
  - Reset mid-window discards the partial window; no output is produced for it.
- Pipeline (beat sampled at edge E):
  - E: lane products, full width 2*DW, signed per SIGNED, plus adjacent-pair sums registered (LANES/2 values).
  - E+1: remaining tree reduced to one tile sum of width 2*DW+log2(LANES), registered.
  - E+2: accumulate stage.
- Accumulate stage:
  - Accumulator empty: acc <= tile sum. Otherwise: acc <= acc + tile sum.
  - Beat counter increments per beat.
  - Sums beyond range saturate: unsigned to 2^ACC_W-1; signed to +2^(ACC_W-1)-1 or -2^(ACC_W-1). Any saturation in the window sets a sticky ovf flag.
- Result timing:
  - When the beat at the accumulate stage carries last, out_ofm, out_ovf and out_count load the final values at edge E+2.
  - out_valid=1 for exactly the following cycle.
  - Accumulator, counter and ovf return to empty at the same edge.
- Flow and boundaries:
  - No backpressure; one beat per cycle, fully pipelined.
  - Back-to-back windows need no bubble: the beat after a last beat starts a fresh window.
  - in_valid=0 gaps inside a window are allowed; the accumulator holds.
  - in_last with in_valid=0 is ignored.
  - Single-beat window (in_valid and in_last on the first beat): result = tile sum, out_count=1.
  - Beat counter saturates and does not wrap; this does not set out_ovf.
  - Output registers update only on a result.

Optional Feature:
- Macro CONV_DOT_ACC_RELU_EN.
- Defined: at result load, a negative final value (SIGNED=1 only) is replaced by 0 before out_ofm; out_ovf is unaffected; no latency change.
- Undefined, or SIGNED=0: out_ofm is the raw saturated result.

Test Plan:
- Defaults, all in_ifm lanes=15, in_weight=15, single beat with in_last=1 -> out_ofm=7200, out_count=1, out_ovf=0; out_valid one cycle, 3 edges after the sampling edge.
- Defaults, 3 beats of all-ones, last on beat 3, one idle cycle between beats 1 and 2 -> out_ofm=96, out_count=3, single out_valid pulse.
- Two back-to-back windows, lanes=15×15 then 1×2 (each 1 beat) -> consecutive out_valid pulses with 7200 then 64.
- SIGNED=1, in_ifm lanes=0x8 (-8), in_weight=7, 1 beat -> out_ofm=-1792 (two's complement 20-bit). With CONV_DOT_ACC_RELU_EN -> out_ofm=0.
- Defaults, 146 beats of 15×15, last on beat 146 -> out_ofm=1048575, out_ovf=1, out_count=146. The next 1-beat window reports out_ovf=0.
- rst_n pulsed low after 2 beats of a window -> outputs 0 immediately. A following 1-beat window of all-ones -> out_ofm=32, out_count=1.
